// File: rtl/decode_pkg.sv
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared types for the decode pipeline: RISC-V opcode map,
//                ALU-op and jump encodings, and the decoded control bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD      = 7'b0000011,
        OPC_OP_IMM    = 7'b0010011,
        OPC_AUIPC     = 7'b0010111,
        OPC_OP_IMM_32 = 7'b0011011,
        OPC_STORE     = 7'b0100011,
        OPC_OP        = 7'b0110011,
        OPC_LUI       = 7'b0110111,
        OPC_OP_32     = 7'b0111011,
        OPC_BRANCH    = 7'b1100011,
        OPC_JALR      = 7'b1100111,
        OPC_JAL       = 7'b1101111,
        OPC_SYSTEM    = 7'b1110011
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_SLEFT  = 2'd1,
        ALU_BRANCH = 2'd2,
        ALU_FUNCT  = 2'd3
    } aluop_e;

    typedef enum logic [1:0] {
        JUMP_NONE = 2'd0,
        JUMP_JAL  = 2'd1,
        JUMP_JALR = 2'd2
    } jump_e;

    // Decoded instruction minus the XLEN-wide immediate, which the
    // instantiating module carries alongside at its own width.
    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        aluop_e     aluop;
        jump_e      jump;
        logic       alu_use_imm;
        logic       reg_wb;
        logic       reg_lui;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       word_op;
        logic       env;
        logic       csr;
        logic       illegal;
    } dec_t;

    localparam logic [31:0] C_INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] C_INSTR_EBREAK = 32'h0010_0073;

endpackage

`default_nettype wire

// File: rtl/decode_logic.sv
// ============================================================================
//  Module      : decode_logic
//  Description : Purely combinational RISC-V instruction decoder producing a
//                control bundle plus a sign-extended XLEN immediate.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_logic
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit RV64_EN = (XLEN == 64)
) (
    input  logic [31:0]     instr,
    output dec_t            dec,
    output logic [XLEN-1:0] imm
);

    dec_t        w_dec;
    logic [31:0] w_imm32;
    logic        w_funct7_ok;

    assign w_funct7_ok = (instr[31:25] == 7'h00) || (instr[31:25] == 7'h20);

    // Opcode decode; every immediate is formed as 32-bit sign-extended first.
    always_comb begin
        w_dec        = '0;
        w_dec.rd     = instr[11:7];
        w_dec.rs1    = instr[19:15];
        w_dec.rs2    = instr[24:20];
        w_dec.funct3 = instr[14:12];
        w_dec.funct7 = instr[31:25];
        w_imm32      = '0;
        case (instr[6:0])
            OPC_LOAD: begin
                w_dec.alu_use_imm = 1'b1;
                w_dec.reg_wb      = 1'b1;
                w_dec.mem_read    = 1'b1;
                w_dec.mem_to_reg  = 1'b1;
                w_imm32           = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                w_dec.alu_use_imm = 1'b1;
                w_dec.mem_write   = 1'b1;
                w_imm32           = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                w_dec.aluop  = ALU_BRANCH;
                w_dec.branch = 1'b1;
                w_imm32      = {{19{instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
            end
            OPC_JAL: begin
                w_dec.jump   = JUMP_JAL;
                w_dec.reg_wb = 1'b1;
                w_imm32      = {{11{instr[31]}}, instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                w_dec.jump        = JUMP_JALR;
                w_dec.reg_wb      = 1'b1;
                w_dec.alu_use_imm = 1'b1;
                w_imm32           = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_LUI: begin
                w_dec.reg_wb      = 1'b1;
                w_dec.reg_lui     = 1'b1;
                w_dec.alu_use_imm = 1'b1;
                w_imm32           = {instr[31:12], 12'h000};
            end
            OPC_AUIPC: begin
                w_dec.reg_wb      = 1'b1;
                w_dec.alu_use_imm = 1'b1;
                w_imm32           = {instr[31:12], 12'h000};
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                w_dec.aluop       = ALU_FUNCT;
                w_dec.alu_use_imm = 1'b1;
                w_dec.reg_wb      = 1'b1;
                w_dec.word_op     = instr[3];
                w_dec.illegal     = instr[3] && !RV64_EN;
                w_imm32           = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_OP, OPC_OP_32: begin
                w_dec.aluop   = ALU_FUNCT;
                w_dec.reg_wb  = 1'b1;
                w_dec.word_op = instr[3];
                w_dec.illegal = !w_funct7_ok || (instr[3] && !RV64_EN);
            end
            OPC_SYSTEM: begin
                if (instr[14:12] != 3'b000) begin
                    w_dec.csr    = 1'b1;
                    w_dec.reg_wb = 1'b1;
                end else if (instr == C_INSTR_ECALL || instr == C_INSTR_EBREAK) begin
                    w_dec.env = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            default: w_dec.illegal = 1'b1;
        endcase

        // Compressed/reserved encodings are not supported.
        if (instr[1:0] != 2'b11) begin
            w_dec.illegal = 1'b1;
        end
        // x0 is never written, including the link register of jal/jalr.
        if (w_dec.rd == 5'd0) begin
            w_dec.reg_wb = 1'b0;
        end
        // An illegal instruction must not trigger any downstream action.
        if (w_dec.illegal) begin
            w_dec.aluop       = ALU_ADD;
            w_dec.jump        = JUMP_NONE;
            w_dec.alu_use_imm = 1'b0;
            w_dec.reg_wb      = 1'b0;
            w_dec.reg_lui     = 1'b0;
            w_dec.branch      = 1'b0;
            w_dec.mem_read    = 1'b0;
            w_dec.mem_write   = 1'b0;
            w_dec.mem_to_reg  = 1'b0;
            w_dec.word_op     = 1'b0;
            w_dec.env         = 1'b0;
            w_dec.csr         = 1'b0;
            w_imm32           = '0;
        end
    end

    assign dec = w_dec;

    generate
        if (XLEN > 32) begin : g_imm_wide
            assign imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_imm_narrow
            assign imm = w_imm32;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/decode_pipe.sv
// ============================================================================
//  Module      : decode_pipe
//  Description : One-stage registered decoder with a 2-entry skid buffer so
//                ready_o is purely a function of registered state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_pipe
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit RV64_EN = (XLEN == 64)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [XLEN-1:0] imm_o,
    output logic [1:0]      aluop_o,
    output logic            alu_use_imm_o,
    output logic            reg_wb_o,
    output logic            reg_lui_o,
    output logic            branch_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            mem_to_reg_o,
    output logic [1:0]      jump_o,
    output logic            word_op_o,
    output logic            env_o,
    output logic            csr_o,
    output logic            illegal_o
);

    typedef struct packed {
        dec_t            dec;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } entry_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    entry_t     r_main;
    entry_t     r_skid;
    entry_t     w_in;
    logic       w_accept;
    logic       w_drain;

    decode_logic #(
        .XLEN    (XLEN),
        .RV64_EN (RV64_EN)
    ) u_decode_logic (
        .instr (instr_i),
        .dec   (w_in.dec),
        .imm   (w_in.imm)
    );

    assign w_in.pc  = pc_i;
    assign w_accept = valid_i && ready_o && !flush_i;
    assign w_drain  = valid_o && ready_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Occupancy transitions; flush empties the buffer unconditionally.
    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_state_next = ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_drain) begin
                        w_state_next = ST_TWO;
                    end else if (w_drain && !w_accept) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_TWO:   if (w_drain) w_state_next = ST_ONE;
                default:  w_state_next = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs decoded from registered state only.
    always_comb begin
        ready_o = (r_state != ST_TWO);
        valid_o = (r_state != ST_EMPTY);
    end

    // Payload registers; main always holds the oldest entry, skid the next.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (!flush_i) begin
            case (r_state)
                ST_EMPTY: if (w_accept) r_main <= w_in;
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        r_main <= w_in;
                    end else if (w_accept) begin
                        r_skid <= w_in;
                    end
                end
                ST_TWO:   if (w_drain) r_main <= r_skid;
                default:  ;
            endcase
        end
    end

    assign pc_o          = r_main.pc;
    assign imm_o         = r_main.imm;
    assign rd_o          = r_main.dec.rd;
    assign rs1_o         = r_main.dec.rs1;
    assign rs2_o         = r_main.dec.rs2;
    assign funct3_o      = r_main.dec.funct3;
    assign funct7_o      = r_main.dec.funct7;
    assign aluop_o       = r_main.dec.aluop;
    assign jump_o        = r_main.dec.jump;
    assign alu_use_imm_o = r_main.dec.alu_use_imm;
    assign reg_wb_o      = r_main.dec.reg_wb;
    assign reg_lui_o     = r_main.dec.reg_lui;
    assign branch_o      = r_main.dec.branch;
    assign mem_read_o    = r_main.dec.mem_read;
    assign mem_write_o   = r_main.dec.mem_write;
    assign mem_to_reg_o  = r_main.dec.mem_to_reg;
    assign word_op_o     = r_main.dec.word_op;
    assign env_o         = r_main.dec.env;
    assign csr_o         = r_main.dec.csr;
    assign illegal_o     = r_main.dec.illegal;

endmodule

`default_nettype wire
